mem_ctrl_ram: RTL and testbench
===============================

# mem_ctrl_ram

Parametrised single-port RAM with valid/ready request handshake, byte-lane write enables, configurable read latency and a hardware clear sequencer. It is the next generation of the team's simple read/write memory: the array is no longer reset by a combinational loop but swept to zero by an FSM, both after reset and on request. It sits behind bus-side masters that need a small scratch store with a defined response timing.

## Interface
- W, 8: data width in bits; must be a multiple of 8.
- L, 10: depth in words; any value ≥ 2, not required to be a power of two.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- AW (local), $clog2(L): address width.
- NB (local), W/8: number of byte lanes.

- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  single-cycle pulse; starts a zero-fill sweep.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = write, 0 = read.
- req_add  in  AW  word address.
- req_wdata  in  W  write data.
- req_be  in  NB  byte enables; bit i covers bits 8i+7:8i.
- rsp_valid  out  1  one-cycle pulse per accepted read.
- rsp_data  out  W  read data; held until the next rsp_valid.
- rsp_err  out  1  qualifies rsp_valid; address was out of range.
- busy  out  1  high while a clear sweep is running.

## Operation
- States: CLEAR, RUN.
- reset_n low: state = CLEAR, sweep counter = 0, read pipeline emptied. Outputs: req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, busy 1. The array contents are not touched by reset.
- CLEAR: writes all-zero to mem[cnt] each cycle, with cnt running 0..L-1.
  - At cnt = L-1, the FSM goes to RUN on the next edge.
  - busy = 1 and req_ready = 0 throughout.
  - clear asserted while in CLEAR is ignored; the sweep does not restart.
- RUN: req_ready = !clear (combinational).
  - clear in RUN: go to CLEAR with cnt = 0; any request in the same cycle is not accepted.
- Accepted write:
  - For each lane with req_be[i] = 1, mem[add] lane i ← req_wdata lane i; other lanes keep their value.
  - If req_be = 0, nothing is written.
  - If add ≥ L, the write is dropped silently.
- Accepted read:
  - If add < L, mem[add] enters the read pipeline.
  - If add ≥ L, 0 enters the pipeline with the error flag set.
- Reads already accepted before a clear still complete with their pre-clear data.
- There is no response backpressure; the master must always sink rsp_valid.

## Timing
- Read accepted at edge t: rsp_valid is high in the cycle after edge t+RD_LAT-1, i.e. RD_LAT cycles after acceptance.
- Back-to-back reads give one response per cycle, in order.
- Write accepted at edge t is visible to a read accepted at edge t+1 (read-after-write returns new data).
- After reset_n deasserts, the sweep takes exactly L edges. req_ready first rises in the cycle after edge L.
- A clear pulse in RUN gives req_ready = 0 immediately and busy = 1 from the next cycle for L cycles.
- Mid-sweep reset_n assertion returns the FSM to CLEAR with cnt = 0, so the full sweep restarts.
- rsp_err is 0 whenever rsp_valid is 0.

## Structure
- Shared package mem_pkg holds:
  - state enum {CLEAR, RUN};
  - RD_LAT legal-value constants;
  - function for lane-masked merge of old and new words.
- Sub-module mem_rd_pipe: RD_LAT-deep valid/data/err shift register, async active-low reset to zero. Instantiated once.
- The array itself is inferred; no reset on the array.

## Test plan
- Reset release, W=16, L=10, RD_LAT=1: busy high for 10 cycles, then req_ready = 1. Reads of addresses 0..9 all return 0x0000.
- Write 0xABCD to add 3 with be=2'b11, then a read of add 3 on the next cycle: rsp_data = 0xABCD exactly 1 cycle after read acceptance.
- Byte lanes: write 0x1234 to add 5 with be=01, then 0xFF00 with be=10. Read add 5 returns 0xFF34.
- Out of range, L=10: write to add 12 is dropped; read of add 12 returns rsp_err = 1 and rsp_data = 0. Neighbouring entries are unchanged.
- RD_LAT=2 streaming: reads of add 0,1,2 on consecutive cycles give three consecutive responses, first 2 cycles after the first acceptance, in order.
- Clear with reads in flight: clear pulses in the same cycle as req_valid, so that request is not accepted. The prior read still returns its old value. busy = 1 for L cycles, then all reads return 0. A reset_n pulse mid-sweep restarts the full L-cycle sweep.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state encoding, latency limits and lane-merge helper for mem_ctrl_ram.
package mem_pkg;

   typedef enum logic {CLEAR, RUN} state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // A lane takes the new byte only when its enable is set.
   function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/mem_ctrl_ram_if.sv
// Request/response bundle between a bus-side master and mem_ctrl_ram.
interface mem_ctrl_ram_if #(
   parameter int W = 8,
   parameter int L = 10
);
   localparam int AW = $clog2(L);
   localparam int NB = W / 8;

   logic          clear;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_add;
   logic [W-1:0]  req_wdata;
   logic [NB-1:0] req_be;
   logic          rsp_valid;
   logic [W-1:0]  rsp_data;
   logic          rsp_err;
   logic          busy;

   modport master (
      output clear, req_valid, req_we, req_add, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_data, rsp_err, busy
   );

   modport slave (
      input  clear, req_valid, req_we, req_add, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_data, rsp_err, busy
   );

endinterface

// File: rtl/mem_rd_pipe.sv
// Read response shift register, DEPTH cycles deep; no backpressure.
// Final data stage only loads on a valid beat, so the response word holds between responses.
module mem_rd_pipe #(
   parameter int W     = 8,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   input  logic         in_err,
   output logic         out_vld,
   output logic [W-1:0] out_dat,
   output logic         out_err
);

   logic [DEPTH-1:0]        vld_q;
   logic [DEPTH-1:0]        err_q;
   logic [DEPTH-1:0][W-1:0] dat_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         err_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q[0] <= in_vld;
         err_q[0] <= in_vld & in_err;
         if (in_vld) dat_q[0] <= in_dat;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_vld = vld_q[DEPTH-1];
   assign out_err = err_q[DEPTH-1];
   assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/mem_ctrl_ram.sv
// Single-port scratch RAM with byte enables and a zero-fill sweep after reset or clear.
// Latency: read data RD_LAT cycles after acceptance; backpressure: req_ready low while sweeping or clear is high.
module mem_ctrl_ram
   import mem_pkg::*;
#(
   parameter int W      = 8,
   parameter int L      = 10,
   parameter int RD_LAT = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   mem_ctrl_ram_if.slave  bus
);

   localparam int AW  = $clog2(L);
   localparam int NB  = W / 8;
   localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                        (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;
   localparam logic [AW-1:0] LAST  = AW'(L - 1);
   localparam logic [AW:0]   L_EXT = (AW + 1)'(L);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   logic [W-1:0]  mem [L];
   logic          in_range;
   logic          wr_acc;
   logic          rd_acc;
   logic [W-1:0]  cur_word;
   logic [W-1:0]  wr_word;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus.req_ready = 1'b0;
      bus.busy      = 1'b0;
      case (state_q)
         CLEAR: begin
            // Clear requests during the sweep are ignored; it never restarts.
            bus.busy = 1'b1;
            if (cnt_q == LAST) state_d = RUN;
            else               cnt_d   = cnt_q + AW'(1);
         end
         RUN: begin
            bus.req_ready = !bus.clear;
            if (bus.clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   assign in_range = {1'b0, bus.req_add} < L_EXT;
   assign wr_acc   = bus.req_valid && bus.req_ready && bus.req_we;
   assign rd_acc   = bus.req_valid && bus.req_ready && !bus.req_we;
   assign cur_word = in_range ? mem[bus.req_add] : '0;

   always_comb begin
      wr_word = cur_word;
      for (int i = 0; i < NB; i++) begin
         wr_word[8*i +: 8] = lane_merge(cur_word[8*i +: 8], bus.req_wdata[8*i +: 8], bus.req_be[i]);
      end
   end

   // The array is deliberately not reset; the sweep is what zeroes it.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR)          mem[cnt_q]       <= '0;
      else if (wr_acc && in_range)   mem[bus.req_add] <= wr_word;
   end

   mem_rd_pipe #(
      .W     (W),
      .DEPTH (LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .in_vld  (rd_acc),
      .in_dat  (cur_word),
      .in_err  (!in_range),
      .out_vld (bus.rsp_valid),
      .out_dat (bus.rsp_data),
      .out_err (bus.rsp_err)
   );

endmodule

// File: tb/tb_mem_ctrl_ram.sv
// Bench for mem_ctrl_ram: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream.
module tb_mem_ctrl_ram;

   localparam int W = 16;
   localparam int L = 10;

   typedef struct {
      logic        we;
      logic [3:0]  add;
      logic [15:0] wd;
      logic [1:0]  be;
      logic [15:0] ed;
      logic        ee;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] dat;
      logic        err;
   } exp_t;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   int          n_chk   = 0;
   int          n_pass  = 0;
   int          cyc     = 0;
   int          sweep_left = L;
   int          n;
   logic [15:0] mm [L];
   exp_t        q [2][$];
   logic [15:0] last_dat [2];
   logic        rv [2];
   logic [15:0] rd [2];
   logic        re [2];
   vec_t        tab [17];

   mem_ctrl_ram_if #(.W(W), .L(L)) b1 ();
   mem_ctrl_ram_if #(.W(W), .L(L)) b2 ();

   assign b2.clear     = b1.clear;
   assign b2.req_valid = b1.req_valid;
   assign b2.req_we    = b1.req_we;
   assign b2.req_add   = b1.req_add;
   assign b2.req_wdata = b1.req_wdata;
   assign b2.req_be    = b1.req_be;

   assign rv[0] = b1.rsp_valid;
   assign rd[0] = b1.rsp_data;
   assign re[0] = b1.rsp_err;
   assign rv[1] = b2.rsp_valid;
   assign rd[1] = b2.rsp_data;
   assign re[1] = b2.rsp_err;

   mem_ctrl_ram #(.W(W), .L(L), .RD_LAT(1)) u_lat1 (.clk(clk), .reset_n(reset_n), .bus(b1));
   mem_ctrl_ram #(.W(W), .L(L), .RD_LAT(2)) u_lat2 (.clk(clk), .reset_n(reset_n), .bus(b2));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   // Reference model: sweep countdown and zero-fill, driven only by clear/reset.
   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         sweep_left = L;
         foreach (mm[i]) mm[i] = 16'h0;
      end else if (b1.clear && sweep_left == 0) begin
         sweep_left = L;
         foreach (mm[i]) mm[i] = 16'h0;
      end else if (sweep_left > 0) begin
         sweep_left--;
      end
   end

   // Response scoreboard for both latencies.
   always @(negedge clk) begin
      if (!reset_n) begin
         for (int d = 0; d < 2; d++) begin
            q[d].delete();
            last_dat[d] = 16'h0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            logic ev;
            exp_t e;
            ev = (q[d].size() > 0) && (q[d][0].due <= cyc);
            check($sformatf("rsp_valid_lat%0d", d + 1), 32'(rv[d]), 32'(ev));
            if (ev) begin
               e = q[d].pop_front();
               check($sformatf("rsp_data_lat%0d", d + 1), 32'(rd[d]), 32'(e.dat));
               check($sformatf("rsp_err_lat%0d", d + 1), 32'(re[d]), 32'(e.err));
               last_dat[d] = e.dat;
            end else begin
               check($sformatf("rsp_err_idle_lat%0d", d + 1), 32'(re[d]), 32'd0);
               check($sformatf("rsp_data_hold_lat%0d", d + 1), 32'(rd[d]), 32'(last_dat[d]));
            end
         end
      end
   end

   task automatic drive(input logic clr, input logic v, input logic we, input logic [3:0] add,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic use_exp, input logic [15:0] ed, input logic ee);
      logic mrdy;
      exp_t e;
      @(negedge clk);
      b1.clear     = clr;
      b1.req_valid = v;
      b1.req_we    = we;
      b1.req_add   = add;
      b1.req_wdata = wd;
      b1.req_be    = be;
      #1;
      mrdy = (sweep_left == 0) && !clr;
      check("req_ready_lat1", 32'(b1.req_ready), 32'(mrdy));
      check("req_ready_lat2", 32'(b2.req_ready), 32'(mrdy));
      check("busy", 32'(b1.busy), 32'(sweep_left != 0));
      if (v && mrdy) begin
         if (we) begin
            if (int'(add) < L)
               for (int i = 0; i < 2; i++)
                  if (be[i]) mm[add][8*i +: 8] = wd[8*i +: 8];
         end else begin
            e.dat = use_exp ? ed : ((int'(add) < L) ? mm[add] : 16'h0);
            e.err = use_exp ? ee : (int'(add) >= L);
            e.due = cyc + 1;
            q[0].push_back(e);
            e.due = cyc + 2;
            q[1].push_back(e);
         end
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic rd_exp(input logic [3:0] add, input logic [15:0] ed);
      drive(1'b0, 1'b1, 1'b0, add, 16'h0, 2'b00, 1'b1, ed, 1'b0);
   endtask

   // Idle cycles until req_ready is seen, bounded.
   task automatic wait_ready(output int cnt);
      cnt = 0;
      do begin
         idle();
         cnt++;
      end while (!b1.req_ready && cnt < 100);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      tab[0]  = '{1'b1, 4'd3,  16'hABCD, 2'b11, 16'h0000, 1'b0};
      tab[1]  = '{1'b0, 4'd3,  16'h0000, 2'b00, 16'hABCD, 1'b0};
      tab[2]  = '{1'b1, 4'd5,  16'h1234, 2'b01, 16'h0000, 1'b0};
      tab[3]  = '{1'b1, 4'd5,  16'hFF00, 2'b10, 16'h0000, 1'b0};
      tab[4]  = '{1'b0, 4'd5,  16'h0000, 2'b00, 16'hFF34, 1'b0};
      tab[5]  = '{1'b1, 4'd12, 16'h5555, 2'b11, 16'h0000, 1'b0};
      tab[6]  = '{1'b0, 4'd12, 16'h0000, 2'b00, 16'h0000, 1'b1};
      tab[7]  = '{1'b0, 4'd2,  16'h0000, 2'b00, 16'h0000, 1'b0};
      tab[8]  = '{1'b0, 4'd9,  16'h0000, 2'b00, 16'h0000, 1'b0};
      tab[9]  = '{1'b0, 4'd3,  16'h0000, 2'b00, 16'hABCD, 1'b0};
      tab[10] = '{1'b1, 4'd0,  16'hFFFF, 2'b00, 16'h0000, 1'b0};
      tab[11] = '{1'b0, 4'd0,  16'h0000, 2'b00, 16'h0000, 1'b0};
      tab[12] = '{1'b1, 4'd1,  16'h1111, 2'b11, 16'h0000, 1'b0};
      tab[13] = '{1'b1, 4'd2,  16'h2222, 2'b11, 16'h0000, 1'b0};
      tab[14] = '{1'b0, 4'd0,  16'h0000, 2'b00, 16'h0000, 1'b0};
      tab[15] = '{1'b0, 4'd1,  16'h0000, 2'b00, 16'h1111, 1'b0};
      tab[16] = '{1'b0, 4'd2,  16'h0000, 2'b00, 16'h2222, 1'b0};

      b1.clear     = 1'b0;
      b1.req_valid = 1'b0;
      b1.req_we    = 1'b0;
      b1.req_add   = 4'h0;
      b1.req_wdata = 16'h0;
      b1.req_be    = 2'b00;

      // Reset state
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", 32'(b1.req_ready), 32'd0);
      check("rst_busy",      32'(b1.busy),      32'd1);
      check("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
      check("rst_rsp_data",  32'(b1.rsp_data),  32'd0);
      check("rst_rsp_err",   32'(b1.rsp_err),   32'd0);
      check("rst_busy_lat2", 32'(b2.busy),      32'd0 + 32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      // Released before edge 1; sweep ends at edge L.
      wait_ready(n);
      check("sweep_edges_after_reset", 32'(n), 32'(L));
      for (int a = 0; a < L; a++) rd_exp(4'(a), 16'h0000);

      foreach (tab[i])
         drive(1'b0, 1'b1, tab[i].we, tab[i].add, tab[i].wd, tab[i].be, !tab[i].we, tab[i].ed, tab[i].ee);

      // Clear with a read in flight; the clear-cycle request must be refused.
      rd_exp(4'd3, 16'hABCD);
      drive(1'b1, 1'b1, 1'b0, 4'd5, 16'h0, 2'b00, 1'b1, 16'hFF34, 1'b0);
      wait_ready(n);
      check("busy_cycles_after_clear", 32'(n - 1), 32'(L));
      for (int a = 0; a < L; a++) rd_exp(4'(a), 16'h0000);

      // Reset in the middle of a sweep restarts the full sweep.
      drive(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0);
      repeat (4) idle();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midsweep_rst_busy",  32'(b1.busy),      32'd1);
      check("midsweep_rst_ready", 32'(b1.req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wait_ready(n);
      check("sweep_edges_after_midsweep_reset", 32'(n), 32'(L));

      // Randomised traffic against the model, with occasional clears.
      for (int k = 0; k < 500; k++) begin
         drive(1'($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)),
               16'($urandom),
               2'($urandom_range(0, 3)),
               1'b0, 16'h0, 1'b0);
      end
      repeat (4) idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
